ram_rd_check: RTL and testbench

Read-back checker for the dual-port RAM test design. It sits on RAM port B, opposite the port-A write sequencer. Once the writer raises `rd_flag`, it sweeps every address, aligns each returned word with its address across the configured RAM read latency, and compares the word against the writer's pattern. It then reports pass/fail, the error count and the first failing address, as debug-visible status.

---
 rtl/ram_chk_pkg.sv | 23 ++
 rtl/ram_rd_pipe.sv | 51 +++++
 rtl/ram_rd_check.sv | 148 ++++++++++++++
 tb/tb_ram_rd_check.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_chk_pkg.sv
// Shared definitions for the RAM read-back checker: FSM encoding,
// expected-data pattern and the supported read-latency range.
package ram_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } chk_state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

  // Width used by exp_data; callers cast the result down to DATA_W.
  localparam int EXP_W = 32;

  // The writer stores each word's own address, zero-extended.
  function automatic logic [EXP_W-1:0] exp_data(input logic [EXP_W-1:0] addr);
    return addr;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Valid+address delay line that shadows the RAM read latency so each
// returned word can be paired with the address that produced it.
module ram_rd_pipe #(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 6
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_addr
);

  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
      logic              w_valid_in;
      logic [ADDR_W-1:0] w_addr_in;
      logic              r_valid;
      logic [ADDR_W-1:0] r_addr;

      if (gi == 0) begin : g_head
        assign w_valid_in = i_valid;
        assign w_addr_in  = i_addr;
      end else begin : g_tail
        assign w_valid_in = g_stage[gi-1].r_valid;
        assign w_addr_in  = g_stage[gi-1].r_addr;
      end

      // One pipeline stage; a flush drops every in-flight read at once.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_valid <= 1'b0;
          r_addr  <= '0;
        end else if (i_flush) begin
          r_valid <= 1'b0;
          r_addr  <= '0;
        end else begin
          r_valid <= w_valid_in;
          r_addr  <= w_addr_in;
        end
      end
    end
  endgenerate

  assign o_valid = g_stage[RD_LAT-1].r_valid;
  assign o_addr  = g_stage[RD_LAT-1].r_addr;

endmodule

// File: rtl/ram_rd_check.sv
// Port-B read-back checker: once the writer signals completion it sweeps
// every address, aligns returned data with its address and reports
// pass/fail, the mismatch count and the first failing address.
module ram_rd_check
  import ram_chk_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rd_flag,
  output logic              o_ram_rd_en,
  output logic [ADDR_W-1:0] o_ram_rd_addr,
  input  logic [DATA_W-1:0] i_ram_rd_data,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_chk_done,
  output logic              o_chk_err,
  output logic [ADDR_W:0]   o_err_cnt,
  output logic [ADDR_W-1:0] o_first_err_addr
);

  localparam int                CNT_W     = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  generate
    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX ||
        DATA_W < ADDR_W || DEPTH > (1 << ADDR_W)) begin : g_bad_cfg
      $error("ram_rd_check: unsupported parameter combination");
    end
  endgenerate

  chk_state_t r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_ram_rd_en;
  logic [ADDR_W-1:0] r_ram_rd_addr;
  (* mark_debug = "true" *) logic              r_chk_done;
  (* mark_debug = "true" *) logic              r_chk_err;
  (* mark_debug = "true" *) logic [CNT_W-1:0]  r_err_cnt;
  (* mark_debug = "true" *) logic [ADDR_W-1:0] r_first_err_addr;

  logic              w_pipe_valid;
  logic [ADDR_W-1:0] w_pipe_addr;
  logic [DATA_W-1:0] w_exp;
  logic              w_mismatch;
  logic [CNT_W-1:0]  w_err_cnt_next;
  logic              w_abort;
  logic              w_last_cmp;

  // Dropping rd_flag mid-sweep abandons the pass and flushes in-flight reads.
  assign w_abort = ((r_state == ST_READ) || (r_state == ST_DRAIN)) && !i_rd_flag;

  ram_rd_pipe #(
    .RD_LAT (RD_LAT),
    .ADDR_W (ADDR_W)
  ) u_pipe (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (w_abort),
    .i_valid (r_ram_rd_en),
    .i_addr  (r_ram_rd_addr),
    .o_valid (w_pipe_valid),
    .o_addr  (w_pipe_addr)
  );

  assign w_exp          = DATA_W'(exp_data(EXP_W'(w_pipe_addr)));
  assign w_mismatch     = w_pipe_valid && (i_ram_rd_data != w_exp);
  assign w_err_cnt_next = r_err_cnt + CNT_W'(w_mismatch);
  assign w_last_cmp     = w_pipe_valid && (w_pipe_addr == LAST_ADDR);

  // Sweep control plus status bookkeeping; entry clears status, abort freezes it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state          <= ST_IDLE;
      r_cnt            <= '0;
      r_ram_rd_en      <= 1'b0;
      r_ram_rd_addr    <= '0;
      r_chk_done       <= 1'b0;
      r_chk_err        <= 1'b0;
      r_err_cnt        <= '0;
      r_first_err_addr <= '0;
    end else begin
      if (w_mismatch) begin
        r_err_cnt <= w_err_cnt_next;
        if (r_err_cnt == '0) begin
          r_first_err_addr <= w_pipe_addr;
        end
      end
      case (r_state)
        ST_IDLE: begin
          if (i_rd_flag) begin
            r_state          <= ST_READ;
            r_cnt            <= '0;
            r_err_cnt        <= '0;
            r_first_err_addr <= '0;
            r_chk_err        <= 1'b0;
          end
        end
        ST_READ: begin
          if (!i_rd_flag) begin
            r_state     <= ST_IDLE;
            r_ram_rd_en <= 1'b0;
          end else begin
            r_ram_rd_en   <= 1'b1;
            r_ram_rd_addr <= r_cnt;
            r_cnt         <= r_cnt + 1'b1;
            if (r_cnt == LAST_ADDR) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          r_ram_rd_en <= 1'b0;
          if (!i_rd_flag) begin
            r_state <= ST_IDLE;
          end else if (w_last_cmp) begin
            // Fold in the final compare so chk_err is right on the same edge.
            r_state    <= ST_DONE;
            r_chk_done <= 1'b1;
            r_chk_err  <= (w_err_cnt_next != '0);
          end
        end
        ST_DONE: begin
          if (!i_rd_flag) begin
            r_state    <= ST_IDLE;
            r_chk_done <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_ram_rd_en      = r_ram_rd_en;
  assign o_ram_rd_addr    = r_ram_rd_addr;
  assign o_rd_valid       = w_pipe_valid;
  assign o_rd_addr        = w_pipe_valid ? w_pipe_addr : '0;
  assign o_rd_data        = w_pipe_valid ? i_ram_rd_data : '0;
  assign o_chk_done       = r_chk_done;
  assign o_chk_err        = r_chk_err;
  assign o_err_cnt        = r_err_cnt;
  assign o_first_err_addr = r_first_err_addr;

endmodule

// File: tb/tb_ram_rd_check.sv
// Bench for ram_rd_check: three checker instances (read latency 1, 2, 3)
// share one RAM image and rd_flag; each has its own port-B latency model.
module tb_ram_rd_check;

  localparam int AW    = 6;
  localparam int DW    = 8;
  localparam int DEPTH = 64;
  localparam int NL    = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rd_flag = 1'b0;

  logic [DW-1:0] mem [DEPTH];

  logic          en_a    [NL];
  logic [AW-1:0] raddr_a [NL];
  logic [DW-1:0] dout_a  [NL];
  logic          vld_a   [NL];
  logic [DW-1:0] data_a  [NL];
  logic [AW-1:0] addr_a  [NL];
  logic          done_a  [NL];
  logic          cerr_a  [NL];
  logic [AW:0]   ecnt_a  [NL];
  logic [AW-1:0] ferr_a  [NL];

  int exp_q [NL][$];
  int n_checks = 0;
  int n_errors = 0;
  int pass_no  = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int lane, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s lane%0d: got %0d, expected %0d", name, lane, got, exp);
    end
  endtask

  for (genvar gi = 0; gi < NL; gi++) begin : g_lane
    localparam int LAT = gi + 1;
    logic [DW-1:0] ram_pipe [LAT];

    always @(posedge clk) begin
      if (en_a[gi]) ram_pipe[0] <= mem[raddr_a[gi]];
      for (int s = 1; s < LAT; s++) ram_pipe[s] <= ram_pipe[s-1];
    end
    assign dout_a[gi] = ram_pipe[LAT-1];

    ram_rd_check #(
      .ADDR_W (AW),
      .DATA_W (DW),
      .DEPTH  (DEPTH),
      .RD_LAT (LAT)
    ) u_dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_rd_flag        (rd_flag),
      .o_ram_rd_en      (en_a[gi]),
      .o_ram_rd_addr    (raddr_a[gi]),
      .i_ram_rd_data    (dout_a[gi]),
      .o_rd_valid       (vld_a[gi]),
      .o_rd_data        (data_a[gi]),
      .o_rd_addr        (addr_a[gi]),
      .o_chk_done       (done_a[gi]),
      .o_chk_err        (cerr_a[gi]),
      .o_err_cnt        (ecnt_a[gi]),
      .o_first_err_addr (ferr_a[gi])
    );
  end

  // Monitor: every aligned strobe must be the next expected (address, word).
  always @(negedge clk) begin
    if (rst_n) begin
      for (int l = 0; l < NL; l++) begin
        if (vld_a[l]) begin
          if (exp_q[l].size() == 0) begin
            chk("stray_strobe", l, 1, 0);
          end else begin
            int e;
            e = exp_q[l].pop_front();
            chk("strobe_addr", l, int'(addr_a[l]), e / 256);
            chk("strobe_data", l, int'(data_a[l]), e % 256);
          end
        end
      end
    end
  end

  function automatic int model_errs(input int upto);
    int n = 0;
    for (int a = 0; a < upto; a++) if (mem[a] != DW'(a)) n++;
    return n;
  endfunction

  function automatic int model_first();
    for (int a = 0; a < DEPTH; a++) if (mem[a] != DW'(a)) return a;
    return 0;
  endfunction

  task automatic check_all_zero(input string tag);
    for (int l = 0; l < NL; l++) begin
      chk({tag, "_en"}, l, int'(en_a[l]), 0);
      chk({tag, "_raddr"}, l, int'(raddr_a[l]), 0);
      chk({tag, "_valid"}, l, int'(vld_a[l]), 0);
      chk({tag, "_data"}, l, int'(data_a[l]), 0);
      chk({tag, "_addr"}, l, int'(addr_a[l]), 0);
      chk({tag, "_done"}, l, int'(done_a[l]), 0);
      chk({tag, "_chk_err"}, l, int'(cerr_a[l]), 0);
      chk({tag, "_err_cnt"}, l, int'(ecnt_a[l]), 0);
      chk({tag, "_first"}, l, int'(ferr_a[l]), 0);
    end
  endtask

  task automatic flush_queues();
    for (int l = 0; l < NL; l++) exp_q[l].delete();
  endtask

  // One pass; abort_at / reset_at give the cycle (after READ entry) at which
  // rd_flag is dropped or reset asserted, -1 for a full pass.
  task automatic run_pass(input int abort_at, input int reset_at);
    int exp_err;
    int exp_first;
    int froz;
    pass_no++;
    exp_err   = model_errs(DEPTH);
    exp_first = model_first();
    for (int l = 0; l < NL; l++)
      for (int a = 0; a < DEPTH; a++) exp_q[l].push_back(a * 256 + int'(mem[a]));
    rd_flag = 1'b1;
    @(posedge clk); #1;
    chk("en_at_entry", 0, int'(en_a[0]), 0);
    for (int c = 1; c <= DEPTH + 12; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        for (int l = 0; l < NL; l++) begin
          chk("first_issue_en", l, int'(en_a[l]), 1);
          chk("first_issue_addr", l, int'(raddr_a[l]), 0);
          chk("entry_err_cnt", l, int'(ecnt_a[l]), 0);
          chk("entry_chk_err", l, int'(cerr_a[l]), 0);
          chk("entry_first", l, int'(ferr_a[l]), 0);
        end
      end
      if (c == abort_at) begin
        rd_flag = 1'b0;
        @(posedge clk); #1;
        flush_queues();
        froz = model_errs(abort_at - 10);
        for (int l = 0; l < NL; l++) begin
          chk("abort_done", l, int'(done_a[l]), 0);
          chk("abort_err_cnt", l, int'(ecnt_a[l]), froz);
          chk("abort_en", l, int'(en_a[l]), 0);
        end
        repeat (5) @(posedge clk);
        #1;
        for (int l = 0; l < NL; l++) begin
          chk("abort_frozen_cnt", l, int'(ecnt_a[l]), froz);
          chk("abort_done_late", l, int'(done_a[l]), 0);
        end
        $display("pass %0d: aborted at cycle %0d, frozen err_cnt=%0d", pass_no, c, froz);
        return;
      end
      if (c == reset_at) begin
        #1 rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        flush_queues();
        rd_flag = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        $display("pass %0d: reset asserted at cycle %0d", pass_no, c);
        return;
      end
      if (c > DEPTH && c <= DEPTH + 5)
        for (int l = 0; l < NL; l++)
          chk("done_timing", l, int'(done_a[l]), int'(c >= DEPTH + 2 + l));
    end
    for (int l = 0; l < NL; l++) begin
      chk("all_strobes_seen", l, exp_q[l].size(), 0);
      chk("done_level", l, int'(done_a[l]), 1);
      chk("no_retrigger_en", l, int'(en_a[l]), 0);
      chk("err_cnt", l, int'(ecnt_a[l]), exp_err);
      chk("first_err_addr", l, int'(ferr_a[l]), exp_first);
      chk("chk_err", l, int'(cerr_a[l]), int'(exp_err != 0));
    end
    $display("pass %0d: full, expected err_cnt=%0d first=%0d", pass_no, exp_err, exp_first);
    rd_flag = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clean_mem();
    for (int a = 0; a < DEPTH; a++) mem[a] = DW'(a);
  endtask

  initial begin
    clean_mem();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_pass(-1, -1);               // clean
    mem[5]  = 8'hFF;
    mem[40] = 8'h00;
    run_pass(-1, -1);               // two injected errors
    run_pass(20, -1);               // abort after 20 reads
    run_pass(-1, -1);               // fresh pass after abort
    clean_mem();
    run_pass(-1, -1);               // rerun: status cleared at entry
    mem[12] = 8'h33;
    run_pass(-1, DEPTH + 1);        // reset during DRAIN
    run_pass(-1, -1);               // normal pass after reset

    repeat (3) begin
      int k;
      clean_mem();
      k = $urandom_range(0, 4);
      repeat (k) mem[$urandom_range(0, DEPTH - 1)] = DW'($urandom);
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
      run_pass(-1, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
